hub75_scan_ctrl: RTL and testbench

Row scheduler sitting above the BCM sequencer and the line-buffer fill engine in the HUB75 pipeline.
- Loads row r+1 from the frame buffer into the back half of a ping-pong line buffer while the BCM sequencer displays row r from the front half.
- Rows are handed over by toggling the buffer select, then launching the BCM cycle.
- Generates frame-boundary events, including the deferred frame-buffer swap.

---
 rtl/hub75_pkg.sv | 10 +
 rtl/hub75_scan_ctrl_if.sv | 34 +++
 rtl/hub75_scan_ctrl.sv | 75 +++++++
 tb/tb_hub75_scan_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared scan-controller state encoding and row-width helper.
package hub75_pkg;

    typedef enum logic [2:0] {IDLE, FILL, WAIT, SWAP, GO, DRAIN} state_e;

    function automatic int row_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// hub75_scan_ctrl_if: run control, fill/BCM handshakes and frame events of the row scheduler.
interface hub75_scan_ctrl_if
    import hub75_pkg::*;
#(
    parameter int N_ROWS     = 32,
    parameter int LOG_N_ROWS = row_w(N_ROWS)
);
    logic                  ctrl_run;
    logic [LOG_N_ROWS-1:0] fill_row;
    logic                  fill_go;
    logic                  fill_rdy;
    logic                  buf_sel;
    logic [LOG_N_ROWS-1:0] bcm_row;
    logic                  bcm_row_first;
    logic                  bcm_go;
    logic                  bcm_rdy;
    logic                  frame_swap_req;
    logic                  frame_swap;
    logic                  frame_start;
    logic                  active;

    modport master (
        input  ctrl_run, fill_rdy, bcm_rdy, frame_swap_req,
        output fill_row, fill_go, buf_sel, bcm_row, bcm_row_first, bcm_go,
               frame_swap, frame_start, active
    );

    modport slave (
        output ctrl_run, fill_rdy, bcm_rdy, frame_swap_req,
        input  fill_row, fill_go, buf_sel, bcm_row, bcm_row_first, bcm_go,
               frame_swap, frame_start, active
    );

endinterface

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: prefetches row r+1 into the back line buffer while row r is displayed,
// then flips the ping-pong select and launches the BCM cycle; defers frame swaps to row 0.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int N_ROWS     = 32,
    parameter int LOG_N_ROWS = row_w(N_ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    hub75_scan_ctrl_if.master bus
);

    state_e                state_q, state_d;
    logic [LOG_N_ROWS-1:0] nxt_row_q, nxt_row_d;
    logic [LOG_N_ROWS-1:0] bcm_row_q, bcm_row_d;
    logic                  buf_sel_q, buf_sel_d;
    logic                  swap_pend_q, swap_pend_d;
    logic                  swap_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            nxt_row_q   <= '0;
            bcm_row_q   <= '0;
            buf_sel_q   <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nxt_row_q   <= nxt_row_d;
            bcm_row_q   <= bcm_row_d;
            buf_sel_q   <= buf_sel_d;
            swap_pend_q <= swap_pend_d;
        end
    end

    // A request landing in the row-0 fill cycle itself is honoured at once.
    assign swap_now = (state_q == FILL) && (nxt_row_q == '0) && (swap_pend_q || bus.frame_swap_req);

    always_comb begin
        state_d     = state_q;
        nxt_row_d   = nxt_row_q;
        bcm_row_d   = bcm_row_q;
        buf_sel_d   = buf_sel_q;
        swap_pend_d = (swap_pend_q || bus.frame_swap_req) && !swap_now;
        case (state_q)
            IDLE: begin
                nxt_row_d = '0;
                state_d   = bus.ctrl_run ? FILL : IDLE;
            end
            FILL:  state_d = WAIT;
            WAIT:  state_d = (bus.fill_rdy && bus.bcm_rdy) ? SWAP : WAIT;
            SWAP: begin
                buf_sel_d = !buf_sel_q;
                bcm_row_d = nxt_row_q;
                nxt_row_d = nxt_row_q + 1'b1;
                state_d   = GO;
            end
            GO:    state_d = bus.ctrl_run ? FILL : DRAIN;
            DRAIN: state_d = bus.bcm_rdy ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    assign bus.fill_row      = nxt_row_q;
    assign bus.fill_go       = state_q == FILL;
    assign bus.frame_start   = (state_q == FILL) && (nxt_row_q == '0);
    assign bus.frame_swap    = swap_now;
    assign bus.buf_sel       = buf_sel_q;
    assign bus.bcm_row       = bcm_row_q;
    assign bus.bcm_row_first = bcm_row_q == '0;
    assign bus.bcm_go        = state_q == GO;
    assign bus.active        = state_q != IDLE;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: event-level model of the row scheduler checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hub75_scan_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hub75_scan_ctrl_if #(.N_ROWS(N)) bus ();
    hub75_scan_ctrl #(.N_ROWS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errs = 0;
    int checks = 0;

    // Fill engine and BCM sequencer: busy for a fixed number of cycles after each go.
    int fill_cnt, bcm_cnt;
    int bcm_lat = 3;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= 0;
            bcm_cnt  <= 0;
        end else begin
            fill_cnt <= bus.fill_go ? 3 : (fill_cnt > 0 ? fill_cnt - 1 : 0);
            bcm_cnt  <= bus.bcm_go ? bcm_lat : (bcm_cnt > 0 ? bcm_cnt - 1 : 0);
        end
    end
    assign bus.fill_rdy = fill_cnt == 0;
    assign bus.bcm_rdy  = bcm_cnt == 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: event never seen", nm);
    endtask

    // Event-level model: countdowns to the next expected fill_go / bcm_go.
    int m_fill_cd, m_go_cd, m_next, m_filled, m_disp;
    bit m_idle, m_wait, m_drain, m_pend, m_buf;
    int q_fill[$], q_bcm[$];
    int n_fs, n_first, n_swap, n_swap0, n_fill;

    task automatic model_init();
        m_fill_cd = -1; m_go_cd = -1; m_next = 0; m_filled = 0; m_disp = 0;
        m_idle = 1; m_wait = 0; m_drain = 0; m_pend = 0; m_buf = 0;
    endtask

    initial model_init();

    always @(negedge clk) begin
        bit e_fill, e_go, e_swap, swap_cyc;
        if (rst) model_init();
        else begin
            e_fill = m_fill_cd == 0;
            e_go   = m_go_cd == 0;
            e_swap = e_fill && m_next == 0 && (m_pend || bus.frame_swap_req);
            chk("fill_go", bus.fill_go, e_fill);
            chk("bcm_go", bus.bcm_go, e_go);
            chk("frame_start", bus.frame_start, e_fill && m_next == 0);
            chk("frame_swap", bus.frame_swap, e_swap);
            chk("buf_sel", bus.buf_sel, m_buf);
            chk("active", bus.active, !m_idle);
            chk("go_exclusive", bus.fill_go && bus.bcm_go, 0);
            if (e_fill) chk("fill_row", bus.fill_row, m_next);
            if (e_go) begin
                chk("bcm_row", bus.bcm_row, m_disp);
                chk("bcm_row_first", bus.bcm_row_first, m_disp == 0);
            end
            if (bus.fill_go) begin q_fill.push_back(int'(bus.fill_row)); n_fill++; end
            if (bus.bcm_go) begin q_bcm.push_back(int'(bus.bcm_row)); if (bus.bcm_row_first) n_first++; end
            if (bus.frame_start) n_fs++;
            if (bus.frame_swap) n_swap++;
            if (bus.frame_swap && bus.fill_go && bus.fill_row == 0) n_swap0++;
            swap_cyc = m_go_cd == 1;
            if (m_fill_cd >= 0) m_fill_cd--;
            if (m_go_cd >= 0) m_go_cd--;
            if (swap_cyc) begin m_buf = !m_buf; m_disp = m_filled; end
            if (m_wait && bus.fill_rdy && bus.bcm_rdy) begin m_wait = 0; m_go_cd = 1; end
            if (e_fill) begin m_filled = m_next; m_next = (m_next + 1) % N; m_wait = 1; end
            m_pend = e_swap ? 1'b0 : (m_pend || bus.frame_swap_req);
            if (m_drain && bus.bcm_rdy) begin m_drain = 0; m_idle = 1; m_next = 0; end
            else if (m_idle && bus.ctrl_run) begin m_idle = 0; m_fill_cd = 0; end
            if (e_go) begin
                if (bus.ctrl_run) m_fill_cd = 0;
                else m_drain = 1;
            end
        end
    end

    task automatic wait_fill(input int row, input string nm);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.fill_go && (row < 0 || int'(bus.fill_row) == row)) return;
        end
        timeout(nm);
    endtask

    task automatic wait_bcm(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.bcm_go) return;
        end
        timeout(nm);
    endtask

    task automatic pulse_req();
        bus.frame_swap_req = 1'b1;
        @(posedge clk); #1;
        bus.frame_swap_req = 1'b0;
    endtask

    initial begin
        int exp5[5] = '{0, 1, 2, 3, 0};
        int gap, nf;
        logic b0;
        bus.ctrl_run = 1'b0;
        bus.frame_swap_req = 1'b0;
        #3;
        chk("rst_fill_go", bus.fill_go, 0);
        chk("rst_bcm_go", bus.bcm_go, 0);
        chk("rst_frame_swap", bus.frame_swap, 0);
        chk("rst_frame_start", bus.frame_start, 0);
        chk("rst_buf_sel", bus.buf_sel, 0);
        chk("rst_fill_row", bus.fill_row, 0);
        chk("rst_bcm_row", bus.bcm_row, 0);
        chk("rst_active", bus.active, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: continuous scan over one full frame and into the next
        q_fill.delete(); q_bcm.delete(); n_fs = 0; n_first = 0;
        bus.ctrl_run = 1'b1;
        @(posedge clk); #1;
        chk("t1_start_latency", bus.fill_go, 1);
        chk("t1_first_row", bus.fill_row, 0);
        repeat (5) wait_bcm("t1_bcm_go");
        @(negedge clk); #1;
        chk("t1_nfill", q_fill.size(), 5);
        chk("t1_nbcm", q_bcm.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t1_fill_seq", q_fill[i], exp5[i]);
            chk("t1_bcm_seq", q_bcm[i], exp5[i]);
        end
        chk("t1_first_cnt", n_first, 2);
        chk("t1_frame_start_cnt", n_fs, 2);
        chk("t1_buf_after5", bus.buf_sel, 1);

        // 2: two requests in one frame give one swap at the next row-0 fill
        n_swap = 0; n_swap0 = 0;
        wait_fill(1, "t2_row1");
        pulse_req();
        wait_fill(2, "t2_row2");
        pulse_req();
        wait_fill(0, "t2_row0a");
        wait_fill(0, "t2_row0b");
        @(negedge clk); #1;
        chk("t2_swap_cnt", n_swap, 1);
        chk("t2_swap_at_row0", n_swap0, 1);

        // 3: request in the very row-0 fill cycle
        wait_fill(0, "t3_row0");
        bus.frame_swap_req = 1'b1;
        #1;
        chk("t3_swap_same_cycle", bus.frame_swap, 1);
        @(posedge clk); #1;
        bus.frame_swap_req = 1'b0;

        // 4: long BCM time stalls the handover
        bcm_lat = 20;
        wait_bcm("t4_go1");
        b0 = bus.buf_sel;
        gap = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            gap++;
            if (bus.bcm_go) break;
        end
        bcm_lat = 3;
        chk("t4_go_gap", gap, 23);
        chk("t4_buf_toggled", bus.buf_sel, !b0);

        // 5: stop while waiting on row 2
        wait_fill(2, "t5_row2");
        @(posedge clk); #1;
        bus.ctrl_run = 1'b0;
        wait_bcm("t5_go");
        chk("t5_bcm_row", bus.bcm_row, 2);
        nf = n_fill;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!bus.active) break;
        end
        chk("t5_idle", bus.active, 0);
        chk("t5_no_prefetch", n_fill - nf, 0);
        bus.ctrl_run = 1'b1;
        @(posedge clk); #1;
        chk("t5_restart_go", bus.fill_go, 1);
        chk("t5_restart_row", bus.fill_row, 0);

        // 6: asynchronous reset during GO
        wait_bcm("t6_go");
        #2;
        rst = 1'b1;
        #1;
        chk("t6_bcm_go", bus.bcm_go, 0);
        chk("t6_active", bus.active, 0);
        chk("t6_buf_sel", bus.buf_sel, 0);
        chk("t6_bcm_row", bus.bcm_row, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_fill_go", bus.fill_go, 1);
        chk("t6_fill_row", bus.fill_row, 0);
        chk("t6_frame_start", bus.frame_start, 1);
        repeat (20) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
